// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi-channel countdown timer: field widths,
// field moduli, field_sel encodings, the packed time layout, the per-channel
// state enum and a modular-add helper used by the field editor.
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int MS_W   = 10;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HR_W   = 5;
    localparam int TIME_W = HR_W + MIN_W + SEC_W + MS_W;  // 27

    localparam int MS_MOD  = 1000;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;

    localparam logic [1:0] FLD_MS  = 2'd0;
    localparam logic [1:0] FLD_SEC = 2'd1;
    localparam logic [1:0] FLD_MIN = 2'd2;
    localparam logic [1:0] FLD_HR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } ch_state_t;

    // Packed so that the struct maps bit-for-bit onto {hr, min, sec, ms}.
    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [MS_W-1:0]  ms;
    } time_t;

    // Add a small increment (<= 10) modulo a field range. Every modulus is
    // larger than the increment, so one conditional subtraction suffices.
    function automatic logic [9:0] wrap_add(input logic [9:0] val,
                                            input logic [3:0] inc,
                                            input logic [9:0] modulus);
        logic [10:0] sum;
        sum = {1'b0, val} + {7'b0, inc};
        if (sum >= {1'b0, modulus})
            sum = sum - {1'b0, modulus};
        return sum[9:0];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// ---------------------------------------------------------------------------
// timer_channel
// One countdown channel: IDLE/RUN/PAUSE/EXPIRED state machine, field editing
// and the ms->sec->min->hr borrow-chain decrement.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   i_tick          shared 1 ms tick
//   i_clear         zero the value, back to IDLE (already gated by ch_sel)
//   i_run_tgl       run/pause toggle               (gated by ch_sel)
//   i_add_ten       add 10 to the selected field   (gated by ch_sel)
//   i_add_one       add 1 to the selected field    (gated by ch_sel)
//   i_field_sel     0 = ms, 1 = sec, 2 = min, 3 = hr
//   o_time          {hr, min, sec, ms}
//   o_running       channel in RUN
//   o_expired       channel in EXPIRED (sticky until clear)
// ---------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_tick,
    input  logic              i_clear,
    input  logic              i_run_tgl,
    input  logic              i_add_ten,
    input  logic              i_add_one,
    input  logic [1:0]        i_field_sel,
    output logic [TIME_W-1:0] o_time,
    output logic              o_running,
    output logic              o_expired
);

    ch_state_t r_state;
    time_t     r_time;

    ch_state_t w_state_cmd, w_state_nxt;
    time_t     w_time_cmd, w_time_nxt, w_dec;
    logic      w_is_zero;
    logic [3:0] w_inc;

    always_comb begin
        w_state_cmd = r_state;
        w_time_cmd  = r_time;
        w_is_zero   = (r_time == '0);
        w_inc       = i_add_ten ? 4'd10 : 4'd1;

        // Commands, highest priority first; a winning command drops the rest.
        if (i_clear) begin
            w_state_cmd = ST_IDLE;
            w_time_cmd  = '0;
        end else if (i_run_tgl) begin
            case (r_state)
                ST_IDLE:  if (!w_is_zero) w_state_cmd = ST_RUN;
                ST_RUN:   w_state_cmd = ST_PAUSE;
                ST_PAUSE: w_state_cmd = ST_RUN;
                default:  ;
            endcase
        end else if ((i_add_ten || i_add_one) &&
                     (r_state == ST_IDLE || r_state == ST_PAUSE)) begin
            case (i_field_sel)
                FLD_MS:  w_time_cmd.ms  = wrap_add(r_time.ms, w_inc, 10'(MS_MOD));
                FLD_SEC: w_time_cmd.sec = SEC_W'(wrap_add({4'b0, r_time.sec}, w_inc, 10'(SEC_MOD)));
                FLD_MIN: w_time_cmd.min = MIN_W'(wrap_add({4'b0, r_time.min}, w_inc, 10'(MIN_MOD)));
                default: w_time_cmd.hr  = HR_W'(wrap_add({5'b0, r_time.hr}, w_inc, 10'(HR_MOD)));
            endcase
        end

        // Borrow chain; only meaningful for a nonzero value.
        w_dec = r_time;
        if (r_time.ms != '0) begin
            w_dec.ms = r_time.ms - 10'd1;
        end else begin
            w_dec.ms = 10'(MS_MOD - 1);
            if (r_time.sec != '0) begin
                w_dec.sec = r_time.sec - 6'd1;
            end else begin
                w_dec.sec = 6'(SEC_MOD - 1);
                if (r_time.min != '0) begin
                    w_dec.min = r_time.min - 6'd1;
                end else begin
                    w_dec.min = 6'(MIN_MOD - 1);
                    w_dec.hr  = r_time.hr - 5'd1;
                end
            end
        end

        // The tick acts on the post-command state, so PAUSE->RUN decrements
        // in the same cycle while RUN->PAUSE does not. A RUN state always
        // implies the value was not edited this cycle, so r_time is current.
        // A zero value can reach RUN only by wrapping a field while paused;
        // it expires on the next tick instead of borrowing past zero.
        w_state_nxt = w_state_cmd;
        w_time_nxt  = w_time_cmd;
        if (i_tick && w_state_cmd == ST_RUN) begin
            if (w_is_zero || w_dec == '0) begin
                w_time_nxt  = '0;
                w_state_nxt = ST_EXPIRED;
            end else begin
                w_time_nxt = w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_time  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_time  <= w_time_nxt;
        end
    end

    assign o_time    = r_time;
    assign o_running = (r_state == ST_RUN);
    assign o_expired = (r_state == ST_EXPIRED);

endmodule

// File: rtl/multi_countdown_timer.sv
// ---------------------------------------------------------------------------
// multi_countdown_timer
// NUM_CH independent hr:min:sec:ms countdown channels sharing a 1 ms tick.
// Holds the tick prescaler, the ch_sel decode and output packing.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   ch_sel       channel addressed by the command strobes (>= NUM_CH: none)
//   field_sel    0 = ms, 1 = sec, 2 = min, 3 = hr
//   add_one      add 1 to the selected field
//   add_ten      add 10 to the selected field
//   run_tgl      run/pause toggle
//   clear        zero the channel, back to IDLE
//   out_time     channel k at [27k+26:27k] as {hr, min, sec, ms}
//   running      per-channel RUN flag
//   expired      per-channel sticky expiry flag
// ---------------------------------------------------------------------------
module multi_countdown_timer
    import timer_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int TICK_DIV = 100000,
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CW-1:0]            ch_sel,
    input  logic [1:0]               field_sel,
    input  logic                     add_one,
    input  logic                     add_ten,
    input  logic                     run_tgl,
    input  logic                     clear,
    output logic [TIME_W*NUM_CH-1:0] out_time,
    output logic [NUM_CH-1:0]        running,
    output logic [NUM_CH-1:0]        expired
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]     r_presc;
    logic              w_tick;
    logic [NUM_CH-1:0] w_sel;

    // Free-running prescaler; tick is the last count of each period.
    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            r_presc <= '0;
        else if (w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Out-of-range ch_sel values match no channel, dropping the command.
        assign w_sel[k] = (ch_sel == CW'(k));

        timer_channel u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_tick      (w_tick),
            .i_clear     (clear   & w_sel[k]),
            .i_run_tgl   (run_tgl & w_sel[k]),
            .i_add_ten   (add_ten & w_sel[k]),
            .i_add_one   (add_one & w_sel[k]),
            .i_field_sel (field_sel),
            .o_time      (out_time[TIME_W*k +: TIME_W]),
            .o_running   (running[k]),
            .o_expired   (expired[k])
        );
    end

endmodule
